// File: rtl/tt_mux_sequencer.sv
// Sequencer that steers an external mux select counter (reset + increment pulses) to a target
// design address, gating that design's enable off during the move and back on at the end.
module tt_mux_sequencer #(
    parameter int ADDR_W    = 10,
    parameter int PULSE_CYC = 2,
    parameter int MAX_ADDR  = 1023,
    parameter int INCR_EN   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int PC_W = $clog2(PULSE_CYC + 1);
    localparam logic [PC_W-1:0]   PH_LOAD = PC_W'(PULSE_CYC - 1);
    // Compared one bit wider so the range check stays meaningful when MAX_ADDR is all ones
    localparam logic [ADDR_W:0]   MAX_EXT = (ADDR_W + 1)'(MAX_ADDR);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DISABLE = 3'd1,
        RST_LO  = 3'd2,
        RST_HI  = 3'd3,
        INC_HI  = 3'd4,
        INC_LO  = 3'd5,
        ENABLE  = 3'd6
    } state_t;

    state_t              state_r;
    logic [PC_W-1:0]     phase_r;
    logic [ADDR_W-1:0]   rem_r;
    logic [ADDR_W-1:0]   tgt_r;
    logic [ADDR_W-1:0]   cur_addr_r;
    logic                cur_valid_r;
    logic                sel_rst_n_r;
    logic                sel_inc_r;
    logic                ena_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    // Sequencer FSM; every output is a register updated on the transition into its cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            phase_r     <= {PC_W{1'b0}};
            rem_r       <= {ADDR_W{1'b0}};
            tgt_r       <= {ADDR_W{1'b0}};
            cur_addr_r  <= {ADDR_W{1'b0}};
            cur_valid_r <= 1'b0;
            sel_rst_n_r <= 1'b1;
            sel_inc_r   <= 1'b0;
            ena_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                // ENABLE is the done cycle; busy is already low so it accepts requests like IDLE
                IDLE, ENABLE: begin
                    state_r <= IDLE;
                    if (req) begin
                        if ({1'b0, addr} > MAX_EXT) begin
                            err_r <= 1'b1;
                        end else begin
                            tgt_r   <= addr;
                            ena_r   <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= DISABLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DISABLE: begin
                    phase_r <= PH_LOAD;
                    if ((INCR_EN != 0) && cur_valid_r && (tgt_r >= cur_addr_r)) begin
                        rem_r <= tgt_r - cur_addr_r;
                        if (tgt_r == cur_addr_r) begin
                            ena_r   <= 1'b1;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ENABLE;
                        end else begin
                            sel_inc_r <= 1'b1;
                            state_r   <= INC_HI;
                        end
                    end else begin
                        rem_r       <= tgt_r;
                        sel_rst_n_r <= 1'b0;
                        state_r     <= RST_LO;
                    end
                end
                RST_LO: begin
                    if (phase_r == {PC_W{1'b0}}) begin
                        sel_rst_n_r <= 1'b1;
                        cur_addr_r  <= {ADDR_W{1'b0}};
                        cur_valid_r <= 1'b1;
                        phase_r     <= PH_LOAD;
                        state_r     <= RST_HI;
                    end else begin
                        phase_r <= phase_r - PC_W'(1);
                    end
                end
                RST_HI, INC_LO: begin
                    if (phase_r == {PC_W{1'b0}}) begin
                        phase_r <= PH_LOAD;
                        if (rem_r == {ADDR_W{1'b0}}) begin
                            ena_r   <= 1'b1;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ENABLE;
                        end else begin
                            sel_inc_r <= 1'b1;
                            state_r   <= INC_HI;
                        end
                    end else begin
                        phase_r <= phase_r - PC_W'(1);
                    end
                end
                INC_HI: begin
                    if (phase_r == {PC_W{1'b0}}) begin
                        sel_inc_r  <= 1'b0;
                        cur_addr_r <= cur_addr_r + ADDR_W'(1);
                        rem_r      <= rem_r - ADDR_W'(1);
                        phase_r    <= PH_LOAD;
                        state_r    <= INC_LO;
                    end else begin
                        phase_r <= phase_r - PC_W'(1);
                    end
                end
                default: begin
                    sel_rst_n_r <= 1'b1;
                    sel_inc_r   <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign ctrl_sel_rst_n = sel_rst_n_r;
    assign ctrl_sel_inc   = sel_inc_r;
    assign ctrl_ena       = ena_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;
    assign cur_addr       = cur_addr_r;

endmodule

// File: tb/tb_tt_mux_sequencer.sv
// Directed bench for tt_mux_sequencer (ADDR_W=11, PULSE_CYC=2, MAX_ADDR=1023, INCR_EN=1):
// vector table of selection requests plus hand sequences for reset, busy and back-to-back cases.
module tb_tt_mux_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req;
    logic [10:0] addr;
    logic        ctrl_sel_rst_n;
    logic        ctrl_sel_inc;
    logic        ctrl_ena;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] cur_addr;

    int checks;
    int errors;
    logic        model_ena;
    logic [10:0] model_cur;

    typedef struct {
        logic [10:0] addr;
        bit          is_err;
        int          r;
        int          n;
        logic [10:0] cur;
    } vec_t;

    vec_t vecs [8];

    tt_mux_sequencer #(
        .ADDR_W    (11),
        .PULSE_CYC (2),
        .MAX_ADDR  (1023),
        .INCR_EN   (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .addr           (addr),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .cur_addr       (cur_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", name, c, got, want);
        end
    endtask

    function automatic logic [5:0] outs();
        return {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done, err};
    endfunction

    // Issue one request and compare the outputs every cycle against the waveform implied by R and N
    task automatic run_vec(input logic [10:0] a, input bit is_err, input int r, input int n,
                           input logic [10:0] cur_exp, input bit pre, input bit noise,
                           input bit chain, input logic [10:0] next_a, input string name);
        int d;
        int last;
        int k;
        logic [5:0] want;
        d    = is_err ? 1 : 2 + 4 * (r + n);
        last = is_err ? 2 : (chain ? d : d + 1);
        if (!pre) begin
            @(negedge clk);
            req  = 1'b1;
            addr = a;
        end
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            if (is_err) begin
                want = {1'b1, 1'b0, model_ena, 1'b0, 1'b0, (c == 1) ? 1'b1 : 1'b0};
                check({name, " cur"}, c, 32'(cur_addr), 32'(model_cur));
            end else begin
                k = c - 2 - 4 * r;
                want[5] = !(r == 1 && c >= 2 && c < 4);
                want[4] = (k >= 0) && (k < 4 * n) && ((k % 4) < 2);
                want[3] = (c >= d);
                want[2] = (c < d);
                want[1] = (c == d);
                want[0] = 1'b0;
                if (c == d) check({name, " cur"}, c, 32'(cur_addr), 32'(cur_exp));
            end
            check({name, " outs"}, c, 32'(outs()), 32'(want));
            if (is_err) begin
                req = 1'b0;
            end else if (chain && c == d) begin
                req  = 1'b1;
                addr = next_a;
            end else if (noise && c < d - 1) begin
                req  = 1'b1;
                addr = 11'd0;
            end else begin
                req = 1'b0;
            end
        end
        if (!is_err) begin
            model_ena = 1'b1;
            model_cur = cur_exp;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_ena = 1'b0;
        model_cur = 11'd0;
        reset_n   = 1'b0;
        req       = 1'b0;
        addr      = 11'd0;

        vecs[0] = '{addr: 11'd3,    is_err: 1'b0, r: 1, n: 3,    cur: 11'd3};
        vecs[1] = '{addr: 11'd5,    is_err: 1'b0, r: 0, n: 2,    cur: 11'd5};
        vecs[2] = '{addr: 11'd1,    is_err: 1'b0, r: 1, n: 1,    cur: 11'd1};
        vecs[3] = '{addr: 11'd1,    is_err: 1'b0, r: 0, n: 0,    cur: 11'd1};
        vecs[4] = '{addr: 11'd1024, is_err: 1'b1, r: 0, n: 0,    cur: 11'd1};
        vecs[5] = '{addr: 11'd0,    is_err: 1'b0, r: 1, n: 0,    cur: 11'd0};
        vecs[6] = '{addr: 11'd1023, is_err: 1'b0, r: 0, n: 1023, cur: 11'd1023};
        vecs[7] = '{addr: 11'd2047, is_err: 1'b1, r: 0, n: 0,    cur: 11'd1023};

        repeat (3) @(posedge clk);
        #1;
        check("reset outs", 0, 32'(outs()), 32'(6'b100000));
        check("reset cur", 0, 32'(cur_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i].addr, vecs[i].is_err, vecs[i].r, vecs[i].n, vecs[i].cur,
                    1'b0, 1'b0, 1'b0, 11'd0, $sformatf("vec%0d", i));
        end

        // Full-path move toward 5 from 1023, interrupted by reset while the first inc pulse is high
        @(negedge clk);
        req  = 1'b1;
        addr = 11'd5;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            req = 1'b0;
        end
        check("midreset inc_hi", 6, 32'(ctrl_sel_inc), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midreset outs", 6, 32'(outs()), 32'(6'b100000));
        check("midreset cur", 6, 32'(cur_addr), 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        model_ena = 1'b0;
        model_cur = 11'd0;
        run_vec(11'd2, 1'b0, 1, 2, 11'd2, 1'b0, 1'b0, 1'b0, 11'd0, "postreset");

        // Requests and addr changes while busy are ignored; done-cycle requests chain directly
        run_vec(11'd3, 1'b0, 0, 1, 11'd3, 1'b0, 1'b1, 1'b1, 11'd3, "busyreq");
        run_vec(11'd3, 1'b0, 0, 0, 11'd3, 1'b1, 1'b0, 1'b1, 11'd4, "chain0");
        run_vec(11'd4, 1'b0, 0, 1, 11'd4, 1'b1, 1'b0, 1'b0, 11'd0, "chain1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_mux_sequencer.md
TT_MUX_SEQUENCER -- requirements
Module: tt_mux_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the design-address width.
REQ-002 SHALL have parameter PULSE_CYC, default 2, the cycles per high phase and per low phase of each control pulse (legal range >=1).
REQ-003 SHALL have parameter MAX_ADDR, default 1023, the highest legal target address (<= 2^ADDR_W-1).
REQ-004 SHALL have parameter INCR_EN, default 1, enabling incremental (no-reset) selection.
REQ-005 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  1  selection request, sampled only while busy=0.
REQ-008 SHALL have port addr  input  ADDR_W  target design address, sampled with req.
REQ-009 SHALL have port ctrl_sel_rst_n  output  1  mux select-counter reset, active low.
REQ-010 SHALL have port ctrl_sel_inc  output  1  mux select-counter increment strobe.
REQ-011 SHALL have port ctrl_ena  output  1  enable of the selected design.
REQ-012 SHALL have port busy  output  1  sequence in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse on sequence completion.
REQ-014 SHALL have port err  output  1  one-cycle pulse on rejected request.
REQ-015 SHALL have port cur_addr  output  ADDR_W  address currently selected on the mux.

Function
REQ-016 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-017 SHALL, with req=1 sampled at cycle 0 while busy=0, and addr<=MAX_ADDR, latch addr and enter DISABLE at cycle 1: ctrl_ena=0, busy=1.
REQ-018 SHALL, for addr>MAX_ADDR, assert err at cycle 1 only; all other outputs and state unchanged.
REQ-019 SHALL choose path after DISABLE: incremental (R=0, N=addr-cur_addr) iff INCR_EN=1, cur_valid=1 and addr>=cur_addr; else full (R=1, N=addr).
REQ-020 SHALL, in full path, drive ctrl_sel_rst_n=0 for PULSE_CYC cycles starting cycle 2, then 1 for PULSE_CYC cycles; cur_addr=0 and cur_valid=1 at end of the low phase.
REQ-021 SHALL then issue N increment pulses, each ctrl_sel_inc=1 for PULSE_CYC cycles then 0 for PULSE_CYC cycles; cur_addr increments by 1 at each inc falling edge.
REQ-022 SHALL assert ctrl_ena=1, done=1 for one cycle and busy=0 at cycle 2+2*PULSE_CYC*(R+N), then return to IDLE.
REQ-023 SHALL, with N=0 and R=0, hold ctrl_ena low for exactly cycle 1 and re-enable at cycle 2.
REQ-024 SHALL ignore req while busy=1; addr changes while busy have no effect.
REQ-025 SHALL accept a req sampled in the done cycle (busy=0), starting a new sequence next cycle.
REQ-026 SHALL keep ctrl_sel_inc=0 whenever ctrl_sel_rst_n=0; the two never overlap.
REQ-027 SHALL hold ctrl_ena, cur_addr unchanged in IDLE.
REQ-028 SHALL use states IDLE, DISABLE, RST_LO, RST_HI, INC_HI, INC_LO, ENABLE; phase counter width clog2(PULSE_CYC+1), remaining-count width ADDR_W.

Reset
REQ-029 SHALL, on reset_n=0 at any time including mid-sequence, immediately force: ctrl_sel_rst_n=1, ctrl_sel_inc=0, ctrl_ena=0, busy=0, done=0, err=0, cur_addr=0, cur_valid=0, state IDLE.
REQ-030 SHALL, after reset, force the first accepted request down the full path.

Verification (PULSE_CYC=2, INCR_EN=1, MAX_ADDR=1023)
REQ-031 SHALL cover: reset, req addr=3 at cycle 0 -> ena low c1, rst_n low c2-3, inc high c6-7,10-11,14-15, ena=1/done c18, cur_addr=3.
REQ-032 SHALL cover: from 3, req addr=5 -> no rst_n pulse, inc high c2-3,6-7, ena/done c10, cur_addr=5.
REQ-033 SHALL cover: from 5, req addr=1 -> full path, one inc pulse c6-7, ena/done c10; and from 1, req addr=1 -> ena low c1 only, done c2.
REQ-034 SHALL cover: req addr=1024 (ADDR_W=11 build) -> err pulse c1, ctrl_ena and cur_addr unchanged; req during busy -> ignored.
REQ-035 SHALL cover: reset_n low during INC_HI -> all outputs at reset values same cycle; next req addr=2 takes full path.
